// File: rtl/regfile_write_queue.sv
// regfile_write_queue: FIFO-buffered write front end for the register array with a youngest-wins read bypass
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1,
  localparam int NR = 2 ** ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              drain_en_i,
  output logic [NR-1:0]     wr_enable_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_hit_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CW-1:0]     count_o,
  output logic [7:0]        drop_cnt_o
);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0] count_q, count_d;
  logic [NR-1:0] wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0] drop_q, drop_d;
  logic ready_q, push, pop;
  logic [ADDR_W-1:0] head_addr;
  // Accept/drain decisions and next state; pop looks only at the current count,
  // so an entry pushed into an empty queue is never popped in the same cycle.
  always_comb begin
    push = in_valid_i && in_ready_o;
    pop = drain_en_i && count_q != '0;
    head_addr = addr_q[head_q];
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    wen_d = (pop && head_addr != '0) ? NR'(1) << head_addr : '0;
    wdata_d = pop ? data_q[head_q] : wdata_q;
    drop_d = (pop && head_addr == '0 && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  // Control state and the registered output stage; reset flushes the queue at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      wen_q <= '0;
      wdata_q <= '0;
      drop_q <= '0;
      ready_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      wen_q <= wen_d;
      wdata_q <= wdata_d;
      drop_q <= drop_d;
      ready_q <= 1'b1;
    end
  end
  // Entry storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_q] <= in_addr_i;
      data_q[tail_q] <= in_data_i;
    end
  end
  // Bypass scan from output stage through head to tail so the youngest match wins.
  always_comb begin
    rd_hit_o = rd_addr_i != '0 && wen_q[rd_addr_i];
    rd_data_o = rd_hit_o ? wdata_q : '0;
    idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q && rd_addr_i != '0 && addr_q[idx] == rd_addr_i) begin
        rd_hit_o = 1'b1;
        rd_data_o = data_q[idx];
      end
    end
  end
  assign in_ready_o = ready_q && count_q != CW'(DEPTH);
  assign wr_enable_o = wen_q;
  assign wr_data_o = wdata_q;
  assign count_o = count_q;
  assign drop_cnt_o = drop_q;
  a_onehot: assert property (@(posedge clk_i) $onehot0(wr_enable_o));
endmodule
